// File: rtl/gcd_lcm_pkg.sv
// Shared types and constants for the GCD/LCM coprocessor sequencer.
package gcd_lcm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GCD,
        DIV,
        MUL,
        DONE
    } gcd_lcm_state_t;

    localparam logic OP_GCD = 1'b0;
    localparam logic OP_LCM = 1'b1;

    // Operation select for the iterative divide/multiply unit
    localparam logic MD_DIV = 1'b0;
    localparam logic MD_MUL = 1'b1;

endpackage

// File: rtl/gcd_lcm_seq_if.sv
// Coprocessor port between the core (master) and the GCD/LCM sequencer (slave).
interface gcd_lcm_seq_if #(
    parameter int WIDTH = 32
);
    // start is sampled only while the sequencer is idle; busy covers the working
    // cycles, then done pulses once and result/ovf hold until the next acceptance.
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             ovf;

    modport master (output start, op, a, b, input busy, done, result, ovf);
    modport slave  (input start, op, a, b, output busy, done, result, ovf);
endinterface

// File: rtl/gcd_lcm_muldiv.sv
// Iterative restoring divider (Q = dividend / divisor) followed by shift-add multiply
// (P = Q * mcand), one bit per step. GCD_LCM_OVF_EN widens the accumulator to 2*WIDTH.
module gcd_lcm_muldiv
    import gcd_lcm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_mode,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic [WIDTH-1:0] i_mcand,
    output logic             o_last,
    output logic [WIDTH-1:0] o_prod_nxt,
    output logic             o_ovf_nxt
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef GCD_LCM_OVF_EN
    localparam int AW = 2 * WIDTH;
`else
    localparam int AW = WIDTH;
`endif

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_rem;
    logic [AW-1:0]    r_mc;
    logic [AW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_rem_sh;
    logic             w_rem_ge;
    logic [WIDTH-1:0] w_rem_sub;
    logic [AW-1:0]    w_acc_nxt;

    // The quotient shifts in from the bottom while the dividend drains out the top
    assign w_rem_sh   = {r_rem, r_q[WIDTH-1]};
    assign w_rem_ge   = (w_rem_sh >= {1'b0, r_d});
    assign w_rem_sub  = w_rem_sh[WIDTH-1:0] - r_d;
    assign w_acc_nxt  = r_q[0] ? (r_acc + r_mc) : r_acc;
    assign o_last     = (r_cnt == CW'(WIDTH - 1));
    assign o_prod_nxt = w_acc_nxt[WIDTH-1:0];
`ifdef GCD_LCM_OVF_EN
    assign o_ovf_nxt  = |w_acc_nxt[AW-1:WIDTH];
`else
    assign o_ovf_nxt  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q   <= '0;
            r_d   <= '0;
            r_rem <= '0;
            r_mc  <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_q   <= i_dividend;
            r_d   <= i_divisor;
            r_rem <= '0;
            r_mc  <= AW'(i_mcand);
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_step) begin
            r_cnt <= o_last ? '0 : r_cnt + CW'(1);
            if (i_mode == MD_DIV) begin
                if (w_rem_ge) begin
                    r_rem <= w_rem_sub;
                    r_q   <= {r_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_rem <= w_rem_sh[WIDTH-1:0];
                    r_q   <= {r_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                // The finished quotient now serves as the multiplier, LSB first
                r_acc <= w_acc_nxt;
                r_mc  <= r_mc << 1;
                r_q   <= r_q >> 1;
            end
        end
    end

endmodule

// File: rtl/gcd_lcm_seq.sv
// GCD/LCM coprocessor sequencer: subtractive Euclid, then divide/multiply for LCM.
// Optional macro GCD_LCM_OVF_EN enables LCM overflow detection on ovf.
module gcd_lcm_seq
    import gcd_lcm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    gcd_lcm_seq_if.slave   bus,
    output gcd_lcm_state_t o_dbg_state
);
    gcd_lcm_state_t   r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_oa;
    logic [WIDTH-1:0] r_ob;
    logic             r_op;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_ovf;

    logic             w_eq;
    logic             w_md_load;
    logic             w_md_step;
    logic             w_md_mode;
    logic             w_md_last;
    logic [WIDTH-1:0] w_prod_nxt;
    logic             w_ovf_nxt;

    // The final GCD step hands A (== G) straight to the divider as the divisor
    assign w_eq      = (r_a == r_b);
    assign w_md_load = (r_state == GCD) && w_eq && (r_op == OP_LCM);
    assign w_md_step = (r_state == DIV) || (r_state == MUL);
    assign w_md_mode = (r_state == MUL) ? MD_MUL : MD_DIV;

    gcd_lcm_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_md_load),
        .i_mode     (w_md_mode),
        .i_step     (w_md_step),
        .i_dividend (r_oa),
        .i_divisor  (r_a),
        .i_mcand    (r_ob),
        .o_last     (w_md_last),
        .o_prod_nxt (w_prod_nxt),
        .o_ovf_nxt  (w_ovf_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_oa     <= '0;
            r_ob     <= '0;
            r_op     <= OP_GCD;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a  <= bus.a;
                        r_b  <= bus.b;
                        r_oa <= bus.a;
                        r_ob <= bus.b;
                        r_op <= bus.op;
                        if ((bus.a == '0) || (bus.b == '0)) begin
                            r_result <= (bus.op == OP_GCD) ? (bus.a | bus.b) : '0;
                            r_ovf    <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= GCD;
                        end
                    end
                end
                GCD: begin
                    if (w_eq) begin
                        if (r_op == OP_GCD) begin
                            r_result <= r_a;
                            r_ovf    <= 1'b0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_state <= DIV;
                        end
                    end else if (r_a > r_b) begin
                        r_a <= r_a - r_b;
                    end else begin
                        r_b <= r_b - r_a;
                    end
                end
                DIV: begin
                    if (w_md_last) r_state <= MUL;
                end
                MUL: begin
                    if (w_md_last) begin
                        r_result <= w_prod_nxt;
                        r_ovf    <= w_ovf_nxt;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.result  = r_result;
    assign bus.ovf     = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_gcd_lcm_seq.sv
// Directed + light random bench for gcd_lcm_seq with an expected-result scoreboard.
module tb_gcd_lcm_seq;
  import gcd_lcm_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  gcd_lcm_state_t dbg_state;

  gcd_lcm_seq_if #(.WIDTH(W)) bus ();

  gcd_lcm_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_ovf_q[$];
  int           exp_lat_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: Euclid by subtraction (step count k), LCM = (a/g)*b in 2W bits
  function automatic void model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] res, output logic ovf, output int lat);
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] p;
    int k;
    x = a;
    y = b;
    k = 0;
    ovf = 1'b0;
    if (a == 0 || b == 0) begin
      res = (op == OP_GCD) ? (a | b) : '0;
      lat = 1;
      return;
    end
    while (x != y) begin
      if (x > y) x = x - y;
      else       y = y - x;
      k++;
    end
    if (op == OP_GCD) begin
      res = x;
      lat = 2 + k;
    end else begin
      p   = (2*W)'(a / x) * (2*W)'(b);
      res = p[W-1:0];
`ifdef GCD_LCM_OVF_EN
      ovf = |p[2*W-1:W];
`endif
      lat = 2 + k + 2 * W;
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; holds start across one rising edge (cycle 0), then scrambles inputs.
  task automatic drive_req(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic o;
    int l;
    model(op, a, b, r, o, l);
    exp_q.push_back(r);
    exp_ovf_q.push_back(o);
    exp_lat_q.push_back(l);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 1'($urandom_range(0, 1));
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // Watches one request to completion; optionally pokes start mid-run and/or in the done cycle.
  task automatic collect(input string tag, input int inject_cyc, input bit start_in_done);
    logic [W-1:0] e_res;
    logic         e_ovf;
    int           e_lat;
    int           cyc;
    bit           seen;
    e_res = exp_q.pop_front();
    e_ovf = exp_ovf_q.pop_front();
    e_lat = exp_lat_q.pop_front();
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc <= e_lat + 8) begin
      @(negedge clk);
      cyc++;
      if (cyc == inject_cyc) begin
        bus.start = 1'b1;
        bus.op    = OP_GCD;
        bus.a     = 9;
        bus.b     = 6;
      end else if (cyc == inject_cyc + 1) begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        check({tag, "_latency"}, 64'(cyc), 64'(e_lat));
        check({tag, "_result"}, 64'(bus.result), 64'(e_res));
        check({tag, "_ovf"}, 64'(bus.ovf), 64'(e_ovf));
        check({tag, "_busy_at_done"}, 64'(bus.busy), 64'(0));
        if (start_in_done) begin
          bus.start = 1'b1;
          bus.op    = OP_GCD;
          bus.a     = 9;
          bus.b     = 6;
        end
      end else begin
        check({tag, "_busy"}, 64'(bus.busy), 64'(e_lat > 1));
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'(1));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(bus.done), 64'(0));
    check({tag, "_busy_after"}, 64'(bus.busy), 64'(0));
    check({tag, "_result_held"}, 64'(bus.result), 64'(e_res));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rop;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = OP_GCD;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_done", 64'(bus.done), 64'(0));
    check("reset_result", 64'(bus.result), 64'(0));
    check("reset_ovf", 64'(bus.ovf), 64'(0));
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    reset = 1'b0;
    @(negedge clk);

    drive_req(OP_GCD, 48, 18);    collect("gcd_48_18", 0, 1'b0);
    drive_req(OP_LCM, 75, 100);   collect("lcm_75_100", 0, 1'b0);
    drive_req(OP_LCM, 5, 25);     collect("lcm_5_25", 0, 1'b0);
    drive_req(OP_GCD, 0, 7);      collect("gcd_0_7", 0, 1'b0);
    drive_req(OP_LCM, 0, 7);      collect("lcm_0_7", 0, 1'b0);
    drive_req(OP_GCD, 0, 0);      collect("gcd_0_0", 0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      ra  = W'($urandom_range(1, 200));
      rb  = W'($urandom_range(1, 200));
      rop = 1'($urandom_range(0, 1));
      drive_req(rop, ra, rb);
      collect($sformatf("rand%0d", i), 0, 1'b0);
    end

    drive_req(OP_LCM, 32'h0001_0000, 32'h0001_0001);
    collect("lcm_ovf", 0, 1'b0);

    // Start during busy is ignored, start in the done cycle is ignored, next cycle accepted
    drive_req(OP_LCM, 75, 100);
    collect("lcm_inject", 10, 1'b1);
    drive_req(OP_GCD, 9, 6);
    collect("gcd_after_done", 0, 1'b0);

    // Reset while dividing aborts without a done
    drive_req(OP_LCM, 75, 100);
    void'(exp_q.pop_back());
    void'(exp_ovf_q.pop_back());
    void'(exp_lat_q.pop_back());
    cyc = 0;
    while (dbg_state != DIV && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_div", 64'(dbg_state), 64'(DIV));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    check("abort_result", 64'(bus.result), 64'(0));
    check("abort_ovf", 64'(bus.ovf), 64'(0));
    check("abort_state", 64'(dbg_state), 64'(IDLE));
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 64'(bus.done), 64'(0));
    end
    drive_req(OP_GCD, 100, 75);
    collect("gcd_100_75", 0, 1'b0);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_lcm_seq.md
# gcd_lcm_seq

Multi-cycle GCD/LCM coprocessor sequencer on the RISC-V core's coprocessor port. It accepts an operand pair and an opcode from the core on a `start` pulse. It runs subtractive Euclid for the GCD and, for LCM, a restoring divide followed by a shift-add multiply (LCM = (a / gcd) * b). It reports `busy`, which the core uses as a pipeline stall, then a one-cycle `done` with a held `result`.

## Interface
- `WIDTH`, 32, operand/result width in bits (≥ 2)
- `clk` input 1: rising-edge clock
- `reset` input 1: synchronous, active-high
- `start` input 1: request; sampled only in IDLE
- `op` input 1: 0 = GCD, 1 = LCM
- `a` input WIDTH: operand A, unsigned
- `b` input WIDTH: operand B, unsigned
- `busy` output 1: high from the cycle after acceptance through the cycle before `done`
- `done` output 1: one-cycle pulse; `result`/`ovf` valid from this cycle
- `result` output WIDTH: GCD or low WIDTH bits of LCM; held until the next acceptance
- `ovf` output 1: LCM exceeded WIDTH bits; held with `result`

## Operation
- States: IDLE, GCD, DIV, MUL, DONE.
- IDLE: `start`=1 accepts the request.
  - Latch A←a, B←b, OA←a, OB←b, op.
  - If a==0 or b==0: result←a|b for GCD or 0 for LCM; ovf←0; go to DONE.
  - Otherwise go to GCD.
- GCD, one step per cycle:
  - A==B: G←A. Go to DONE with result←G if op=GCD; otherwise go to DIV.
  - A>B: A←A−B.
  - Else: B←B−A.
- DIV: restoring division Q=OA/G, one quotient bit per cycle, MSB first, exactly WIDTH cycles. Remainder is always 0 and is discarded.
- MUL: shift-add product P=Q*OB, one multiplier bit per cycle, exactly WIDTH cycles. Then go to DONE with result←P[WIDTH-1:0] and ovf per Configuration.
- DONE: `done`=1 for one cycle, then return to IDLE.
  - `start` in the DONE cycle is ignored.
  - A new request is accepted no earlier than the following cycle.
- `start` while not in IDLE is ignored. No queuing.
- `a`, `b` and `op` are don't-care except in the accepting cycle.
- All arithmetic is unsigned modulo 2^WIDTH internally; the product accumulator width is per Configuration.

## Timing
- Reset values: state=IDLE, busy=0, done=0, result=0, ovf=0. All internal registers are cleared.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values. No `done` is issued for the aborted request.
- Cycle 0 = the edge at which `start` is sampled in IDLE. k = number of GCD subtraction steps.
  - Zero operand: `done` in cycle 1, with `busy` never asserted.
  - GCD: `done` in cycle 2+k.
  - LCM: `done` in cycle 2+k+2·WIDTH.
- `result` and `ovf` update in the same edge that enters DONE. Both stay stable until the edge following the next acceptance.

## Configuration
- `GCD_LCM_OVF_EN` defined:
  - MUL uses a 2·WIDTH accumulator.
  - ovf = |P[2·WIDTH-1:WIDTH], registered on entry to DONE.
- Not defined:
  - WIDTH-bit accumulator; upper bits are never computed.
  - `ovf` is constant 0; the port remains.
  - `result` and latency are unchanged.

## Structure
- Package `gcd_lcm_pkg`:
  - state enum `gcd_lcm_state_t` (IDLE, GCD, DIV, MUL, DONE)
  - opcode constants `OP_GCD`=1'b0, `OP_LCM`=1'b1
- Sub-module `gcd_lcm_muldiv`:
  - the iterative divide/multiply unit with a `load`/`mode`/`step` interface and a WIDTH-cycle bit counter
  - contains the `GCD_LCM_OVF_EN` accumulator sizing
- `gcd_lcm_seq` owns the FSM, the GCD subtractor, operand latches and output registers.

## Test plan
- GCD a=48, b=18 -> `done` in cycle 6 (k=4), result=6, ovf=0, `busy` high in cycles 1–5.
- LCM a=75, b=100 -> result=300; LCM a=5, b=25 -> result=25. `done` in cycle 2+k+64 for WIDTH=32 (k from the GCD step count).
- Zero operands:
  - GCD a=0, b=7 -> result=7 in cycle 1.
  - LCM a=0, b=7 -> result=0.
  - GCD a=0, b=0 -> result=0.
  - In all three cases `busy` stays 0.
- LCM a=0x10000, b=0x10001 -> result=0x00010000; ovf=1 with `GCD_LCM_OVF_EN` defined, 0 without.
- Request handling:
  - `start` with a=9, b=6 during a busy LCM -> ignored; the first result (LCM) is unchanged.
  - `start` in the DONE cycle -> ignored.
  - `start` the next cycle -> accepted.
- Reset asserted in DIV -> outputs at reset values next cycle. A subsequent GCD a=100, b=75 completes with result=25.
